// File: rtl/guess_round_ctrl_if.sv
// Player-facing bundle of the guessing-game round sequencer: the time base,
// the buttons, the keypad, the latched target and the display/beeper outputs.
interface guess_round_ctrl_if #(
    parameter int LIVES = 16
);
    logic             tick;
    logic             enter;
    logic             test;
    logic [3:0]       key_choose;
    logic [3:0]       keyin;
    logic [15:0]      target;
    logic [15:0]      guess;
    logic [3:0]       pat_sel;
    logic [LIVES-1:0] life;
    logic             beep_en;
    logic             over;

    // master drives the buttons/keypad and observes the round outputs
    modport master (
        output tick, enter, test, key_choose, keyin, target,
        input  guess, pat_sel, life, beep_en, over
    );

    modport slave (
        input  tick, enter, test, key_choose, keyin, target,
        output guess, pat_sel, life, beep_en, over
    );
endinterface

// File: rtl/guess_round_ctrl.sv
// Round sequencer for the four-digit code-guessing game: guess entry, comparison
// against the target latched at reset, life bar, win/lose states and beeper timing.
module guess_round_ctrl #(
    parameter int LIVES           = 16,
    parameter int HINT_TICKS      = 500,
    parameter int BEEP_WIN_TICKS  = 2000,
    parameter int BEEP_MISS_TICKS = 100
) (
    input  logic              CLK,
    input  logic              RST,
    guess_round_ctrl_if.slave bus
);
    localparam int HINT_W   = $clog2(HINT_TICKS + 1);
    localparam int BEEP_MAX = (BEEP_WIN_TICKS > BEEP_MISS_TICKS) ? BEEP_WIN_TICKS : BEEP_MISS_TICKS;
    localparam int BEEP_W   = $clog2(BEEP_MAX + 1);

    typedef enum logic [2:0] {
        ST_ENTRY,
        ST_CHECK,
        ST_HINT,
        ST_WIN,
        ST_LOSE
    } state_t;

    state_t           state_reg;
    logic             enter_q_reg;
    logic             enter_prev_reg;
    logic             test_q_reg;
    logic             test_prev_reg;
    logic [15:0]      target_reg;
    logic [15:0]      guess_reg;
    logic [3:0]       pat_sel_reg;
    logic [LIVES-1:0] life_reg;
    logic             beep_en_reg;
    logic             over_reg;
    logic [HINT_W-1:0] hint_cnt_reg;
    logic [BEEP_W-1:0] beep_cnt_reg;
    logic [BEEP_W-1:0] beep_cnt_next;

    logic             enter_rise;
    logic             test_rise;
    logic [3:0]       dig_eq;
    logic [3:0]       dig_lt;
    logic             all_eq;
    logic             miss_low;
    logic             key_onehot;
    logic             key_valid;
    logic [1:0]       slot;
    logic [15:0]      guess_wr;
    logic [LIVES-1:0] life_shift;

    // Buttons are sampled once and compared with the previous sample, so a held
    // level produces a single rise and the action lands one edge after sampling.
    assign enter_rise = enter_q_reg & ~enter_prev_reg;
    assign test_rise  = test_q_reg & ~test_prev_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign dig_eq[gi]         = (guess_reg[4*gi +: 4] == target_reg[4*gi +: 4]);
            assign dig_lt[gi]         = (guess_reg[4*gi +: 4] <  target_reg[4*gi +: 4]);
            assign guess_wr[4*gi +: 4] = bus.key_choose[gi] ? bus.keyin : guess_reg[4*gi +: 4];
        end
    endgenerate

    assign all_eq     = &dig_eq;
    assign life_shift = {life_reg[LIVES-2:0], 1'b0};

    // Digit 0 is the most significant, so the lowest-indexed mismatch decides the hint.
    always_comb begin
        logic found;
        found    = 1'b0;
        miss_low = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!found && !dig_eq[i]) begin
                found    = 1'b1;
                miss_low = dig_lt[i];
            end
        end
    end

    always_comb begin
        key_onehot = 1'b1;
        slot       = 2'd0;
        case (bus.key_choose)
            4'b0001: slot = 2'd0;
            4'b0010: slot = 2'd1;
            4'b0100: slot = 2'd2;
            4'b1000: slot = 2'd3;
            default: key_onehot = 1'b0;
        endcase
        key_valid = key_onehot && (bus.keyin <= 4'd9);
    end

    // A load in CHECK takes precedence over a coincident tick.
    always_comb begin
        beep_cnt_next = beep_cnt_reg;
        if (bus.tick && (beep_cnt_reg != '0)) begin
            beep_cnt_next = beep_cnt_reg - 1'b1;
        end
        if (state_reg == ST_CHECK) begin
            beep_cnt_next = all_eq ? BEEP_W'(BEEP_WIN_TICKS) : BEEP_W'(BEEP_MISS_TICKS);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= ST_ENTRY;
            enter_q_reg    <= bus.enter;
            enter_prev_reg <= bus.enter;
            test_q_reg     <= bus.test;
            test_prev_reg  <= bus.test;
            target_reg     <= bus.target;
            guess_reg      <= '0;
            pat_sel_reg    <= 4'd1;
            life_reg       <= '1;
            beep_en_reg    <= 1'b0;
            over_reg       <= 1'b0;
            hint_cnt_reg   <= '0;
            beep_cnt_reg   <= '0;
        end else begin
            enter_q_reg    <= bus.enter;
            enter_prev_reg <= enter_q_reg;
            test_q_reg     <= bus.test;
            test_prev_reg  <= test_q_reg;
            beep_cnt_reg   <= beep_cnt_next;
            beep_en_reg    <= (beep_cnt_next != '0);

            case (state_reg)
                ST_ENTRY: begin
                    if (test_rise) begin
                        state_reg <= ST_CHECK;
                    end else if (enter_rise) begin
                        if (key_valid) begin
                            guess_reg   <= guess_wr;
                            pat_sel_reg <= 4'd5 + {2'b00, slot};
                        end else begin
                            pat_sel_reg <= 4'd0;
                        end
                    end
                end
                ST_CHECK: begin
                    if (all_eq) begin
                        pat_sel_reg <= 4'd2;
                        over_reg    <= 1'b1;
                        state_reg   <= ST_WIN;
                    end else begin
                        life_reg <= life_shift;
                        if (life_shift == '0) begin
                            pat_sel_reg <= 4'd9;
                            over_reg    <= 1'b1;
                            state_reg   <= ST_LOSE;
                        end else begin
                            pat_sel_reg  <= miss_low ? 4'd3 : 4'd4;
                            hint_cnt_reg <= HINT_W'(HINT_TICKS);
                            state_reg    <= ST_HINT;
                        end
                    end
                end
                ST_HINT: begin
                    if (bus.tick) begin
                        if (hint_cnt_reg <= HINT_W'(1)) begin
                            state_reg <= ST_ENTRY;
                        end
                        if (hint_cnt_reg != '0) begin
                            hint_cnt_reg <= hint_cnt_reg - 1'b1;
                        end
                    end
                end
                ST_WIN, ST_LOSE: begin
                    over_reg <= 1'b1;
                end
                default: begin
                    state_reg <= ST_ENTRY;
                end
            endcase
        end
    end

    assign bus.guess   = guess_reg;
    assign bus.pat_sel = pat_sel_reg;
    assign bus.life    = life_reg;
    assign bus.beep_en = beep_en_reg;
    assign bus.over    = over_reg;
endmodule

// File: tb/tb_guess_round_ctrl.sv
// Directed bench for guess_round_ctrl: entry, hints, life loss, lose, win and
// beep durations, with hand-computed expectations.
module tb_guess_round_ctrl;
    localparam int LIVES = 16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    guess_round_ctrl_if #(.LIVES(LIVES)) bus ();

    guess_round_ctrl #(
        .LIVES          (LIVES),
        .HINT_TICKS     (500),
        .BEEP_WIN_TICKS (2000),
        .BEEP_MISS_TICKS(100)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic press_enter(input logic [3:0] kc, input logic [3:0] kv);
        bus.key_choose = kc;
        bus.keyin      = kv;
        bus.enter      = 1'b1;
        repeat (3) @(negedge clk);
        bus.enter = 1'b0;
        @(negedge clk);
        $display("txn enter key_choose=%b keyin=%0d -> pat_sel=%0d guess=%h", kc, kv, bus.pat_sel, bus.guess);
    endtask

    task automatic press_test();
        bus.test = 1'b1;
        repeat (3) @(negedge clk);
        bus.test = 1'b0;
        @(negedge clk);
        $display("txn test -> pat_sel=%0d life=%h over=%b beep=%b", bus.pat_sel, bus.life, bus.over, bus.beep_en);
    endtask

    task automatic give_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick = 1'b1;
            @(negedge clk);
            bus.tick = 1'b0;
            @(negedge clk);
        end
    endtask

    // Consumes ticks one at a time until beep_en drops; returns ticks spent high.
    task automatic count_beep(input int limit, output int cnt);
        cnt = 0;
        while (bus.beep_en && cnt < limit) begin
            bus.tick = 1'b1;
            @(negedge clk);
            bus.tick = 1'b0;
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        int          cnt;
        logic [15:0] exp_life;

        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bus.tick       = 1'b0;
        bus.enter      = 1'b0;
        bus.test       = 1'b0;
        bus.key_choose = 4'b0000;
        bus.keyin      = 4'd0;
        bus.target     = 16'h1836;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_pat", bus.pat_sel, 1);
        check_val("rst_guess", bus.guess, 16'h0000);
        check_val("rst_life", bus.life, 16'hFFFF);
        check_val("rst_beep", bus.beep_en, 0);
        check_val("rst_over", bus.over, 0);

        // guess 6,3,2,1 -> third digit low
        press_enter(4'b0001, 4'd6); check_val("wr0_pat", bus.pat_sel, 5); check_val("wr0_guess", bus.guess, 16'h0006);
        press_enter(4'b0010, 4'd3); check_val("wr1_pat", bus.pat_sel, 6); check_val("wr1_guess", bus.guess, 16'h0036);
        press_enter(4'b0100, 4'd2); check_val("wr2_pat", bus.pat_sel, 7); check_val("wr2_guess", bus.guess, 16'h0236);
        press_enter(4'b1000, 4'd1); check_val("wr3_pat", bus.pat_sel, 8); check_val("wr3_guess", bus.guess, 16'h1236);
        press_test();
        check_val("miss1_pat", bus.pat_sel, 3);
        check_val("miss1_life", bus.life, 16'hFFFE);
        check_val("miss1_over", bus.over, 0);
        check_val("miss1_beep", bus.beep_en, 1);
        count_beep(300, cnt);
        check_val("miss1_beep_ticks", cnt, 100);

        // 100 of the 500 hint ticks are gone; one short of the end entry is still blocked
        give_ticks(399);
        press_enter(4'b1000, 4'd0);
        check_val("hint_ignore_pat", bus.pat_sel, 3);
        check_val("hint_ignore_guess", bus.guess, 16'h1236);
        give_ticks(1);
        press_enter(4'b0001, 4'd7);
        check_val("rearm_pat", bus.pat_sel, 5);
        check_val("rearm_guess", bus.guess, 16'h1237);

        press_test();
        check_val("miss2_pat", bus.pat_sel, 4);
        check_val("miss2_life", bus.life, 16'hFFFC);
        give_ticks(500);
        check_val("miss2_beep_off", bus.beep_en, 0);

        press_enter(4'b0001, 4'd12);
        check_val("badkey_pat", bus.pat_sel, 0);
        check_val("badkey_guess", bus.guess, 16'h1237);
        press_enter(4'b0011, 4'd5);
        check_val("multihot_pat", bus.pat_sel, 0);
        check_val("multihot_guess", bus.guess, 16'h1237);
        press_enter(4'b0000, 4'd5);
        check_val("nokey_pat", bus.pat_sel, 0);

        // held enter: one write only, even with the keypad changing underneath
        bus.key_choose = 4'b0010;
        bus.keyin      = 4'd9;
        bus.enter      = 1'b1;
        repeat (3) @(negedge clk);
        check_val("hold_first_guess", bus.guess, 16'h1297);
        bus.keyin = 4'd4;
        repeat (10000) @(negedge clk);
        bus.enter = 1'b0;
        @(negedge clk);
        $display("txn held enter 10000 cycles -> pat_sel=%0d guess=%h", bus.pat_sel, bus.guess);
        check_val("hold_guess", bus.guess, 16'h1297);
        check_val("hold_pat", bus.pat_sel, 6);

        // enter and test rise together: test wins, compares old guess
        bus.key_choose = 4'b0001;
        bus.keyin      = 4'd6;
        bus.enter      = 1'b1;
        bus.test       = 1'b1;
        repeat (3) @(negedge clk);
        bus.enter = 1'b0;
        bus.test  = 1'b0;
        @(negedge clk);
        $display("txn enter+test together -> pat_sel=%0d guess=%h life=%h", bus.pat_sel, bus.guess, bus.life);
        check_val("both_pat", bus.pat_sel, 4);
        check_val("both_guess", bus.guess, 16'h1297);
        check_val("both_life", bus.life, 16'hFFF8);
        give_ticks(500);

        // reset mid-HINT with the beeper still on, new target latched
        press_test();
        check_val("miss4_life", bus.life, 16'hFFF0);
        give_ticks(50);
        bus.target = 16'h0042;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("txn reset mid-hint");
        check_val("rst2_pat", bus.pat_sel, 1);
        check_val("rst2_guess", bus.guess, 16'h0000);
        check_val("rst2_life", bus.life, 16'hFFFF);
        check_val("rst2_beep", bus.beep_en, 0);
        check_val("rst2_over", bus.over, 0);
        press_enter(4'b0001, 4'd2);
        check_val("rst2_entry_pat", bus.pat_sel, 5);
        press_enter(4'b0010, 4'd5);
        check_val("rst2_guess_wr", bus.guess, 16'h0052);

        // 0x0052 vs 0x0042: digit 1 high; old target would have said low
        exp_life = 16'hFFFF;
        for (int k = 1; k <= 16; k++) begin
            press_test();
            exp_life = exp_life << 1;
            check_val($sformatf("lose%0d_life", k), bus.life, exp_life);
            check_val($sformatf("lose%0d_pat", k), bus.pat_sel, (k < 16) ? 4 : 9);
            check_val($sformatf("lose%0d_over", k), bus.over, (k < 16) ? 0 : 1);
            if (k < 16) give_ticks(500);
        end
        press_enter(4'b0001, 4'd0);
        press_test();
        check_val("lose_hold_pat", bus.pat_sel, 9);
        check_val("lose_hold_guess", bus.guess, 16'h0052);
        check_val("lose_hold_life", bus.life, 16'h0000);
        check_val("lose_hold_over", bus.over, 1);

        // reset with enter held: no false edge afterwards
        bus.target = 16'h1836;
        bus.enter  = 1'b1;
        rst        = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst3_held_pat", bus.pat_sel, 1);
        check_val("rst3_held_guess", bus.guess, 16'h0000);
        bus.enter = 1'b0;
        @(negedge clk);

        press_enter(4'b0001, 4'd6); check_val("win_wr0", bus.pat_sel, 5);
        press_enter(4'b0010, 4'd3); check_val("win_wr1", bus.pat_sel, 6);
        press_enter(4'b0100, 4'd8); check_val("win_wr2", bus.pat_sel, 7);
        press_enter(4'b1000, 4'd1); check_val("win_wr3", bus.pat_sel, 8);
        check_val("win_guess", bus.guess, 16'h1836);
        press_test();
        check_val("win_pat", bus.pat_sel, 2);
        check_val("win_over", bus.over, 1);
        check_val("win_life", bus.life, 16'hFFFF);
        count_beep(2500, cnt);
        check_val("win_beep_ticks", cnt, 2000);
        press_enter(4'b0001, 4'd0);
        press_test();
        check_val("win_hold_pat", bus.pat_sel, 2);
        check_val("win_hold_guess", bus.guess, 16'h1836);
        check_val("win_hold_over", bus.over, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/guess_round_ctrl.md
# guess_round_ctrl

Round sequencer for the four-digit code-guessing game. It owns the guess register file, the comparison against a latched target, the life bar, the win/lose terminal states and beeper timing. It drives the pattern-select code consumed by the 8x8 matrix pattern ROM, plus the digit values consumed by the seven-segment scanner. It replaces the ad-hoc flag/RGB_flag logic with a single registered FSM clocked at full CLK rate, with time bases derived from a tick enable.

## Interface
- LIVES, 16: width of the life bar; one bit is lost per wrong guess.
- HINT_TICKS, 500: ticks the hint pattern is held before entry is re-armed.
- BEEP_WIN_TICKS, 2000: ticks beep_en stays high after a win.
- BEEP_MISS_TICKS, 100: ticks beep_en stays high after a wrong guess.

- CLK  in  1  system clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset; also latches `target`.
- tick  in  1  single-CLK-cycle time-base pulse from the divider; used only by the timers.
- enter  in  1  level from the button; acted on at its rising edge.
- test  in  1  level from the button; acted on at its rising edge.
- key_choose  in  4  one-hot digit slot select; bit0 selects digit 0, the most significant digit.
- keyin  in  4  keypad value; valid 0..9.
- target  in  16  four BCD digits, [3:0] = digit 0; sampled only while RST=1.
- guess  out  16  current guess digits, same packing as `target`.
- pat_sel  out  4  matrix pattern code: 0 error, 1 idle, 2 win, 3 go higher, 4 go lower, 5..8 slot 0..3 written, 9 lose.
- life  out  LIVES  life bar; all ones means full.
- beep_en  out  1  beeper gate.
- over  out  1  high in WIN or LOSE.

## Operation
- Reset values: guess=0, pat_sel=1, life=all ones, beep_en=0, over=0, state=ENTRY, timers=0, edge registers=current input levels (no false edge after reset); target register <= target.
- Edge detect: enter and test are each registered once; rise = input & ~prev.
- ENTRY, enter rise with test rise absent:
  - key_choose one-hot and keyin<=9: write that slot; pat_sel=5+slot.
  - keyin>9: no write; pat_sel=0.
  - key_choose not one-hot (0 or multi-bit): no write; pat_sel=0.
- ENTRY, test rise: go to CHECK. If enter also rises that cycle, test wins and the enter rise is discarded.
- CHECK (one cycle): compare digits MSB-first, digit 0 to digit 3, unsigned 4-bit.
  - All equal: pat_sel=2; beep timer=BEEP_WIN_TICKS; go to WIN.
  - Otherwise take the first differing digit: guess<target gives pat_sel=3, else pat_sel=4.
  - On a miss: life <= life<<1 (zero fill); beep timer=BEEP_MISS_TICKS.
  - If the shifted life==0: pat_sel=9; go to LOSE.
  - Else go to HINT with the hint timer=HINT_TICKS.
- HINT: enter and test rises are ignored. The hint timer decrements on tick; on tick with timer==1, go to ENTRY. pat_sel holds until the next entry action.
- WIN/LOSE: terminal. Inputs are ignored, over=1, pat_sel holds. Only RST exits.
- Beep: beep_en=1 while the beep timer is nonzero; the timer decrements on tick; it runs in any state.
- Guess digits are never cleared except by RST.

## Timing
- Every output is registered.
- enter rise at edge N: the edge is detected from the registered copy, guess/pat_sel update at edge N+1.
- test rise: CHECK is entered at N+1. Result pat_sel/life/over are visible at N+2; over is asserted on the same edge as pat_sel=2 or 9.
- beep_en rises on the same edge as the CHECK result. It falls on the edge after the tick that brings the timer to 0, i.e. exactly the parameter count of ticks.
- tick coincident with the CHECK cycle is not applied to the newly loaded timer.
- RST takes priority over every state and over tick; it is applied on the edge where it is sampled high. Reset during CHECK/HINT discards any pending life loss or return.
- Held buttons generate one action only. A second action requires a low level for at least one CLK.

## Test plan
- Reset with target=0x1836 (digits 6,3,8,1); enter rises for slots 0..3 with 6,3,8,1; then test rise → pat_sel 5,6,7,8 in turn, then pat_sel=2, over=1, life=0xFFFF, beep_en high for exactly 2000 ticks.
- Same target, guess 6,3,2,1; test → pat_sel=3, life=0xFFFE, beep 100 ticks, HINT for 500 ticks, then enter accepted again.
- Guess 7,0,0,0 → pat_sel=4. keyin=12 with key_choose=0001 → pat_sel=0, guess unchanged. key_choose=0011 → pat_sel=0, no write.
- 16 consecutive wrong guesses → life shifts down to 0. The 16th gives pat_sel=9, over=1; further enter/test rises change nothing.
- enter and test rise on the same cycle → CHECK runs on the old guess, no write. Hold enter for 10k cycles → exactly one write.
- RST pulse mid-HINT → next cycle: all reset values, life full, target re-latched.
